// File: rtl/sr04_scan_ctrl.sv
// sr04_scan_ctrl -- round-robin HC-SR04 trigger/echo sequencer for four sensors, reporting distance in cm.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module sr04_scan_ctrl #(
   parameter int TRIG_CYC    = 500,
   parameter int CYC_PER_CM  = 2900,
   parameter int TIMEOUT_CYC = 1900000,
   parameter int GAP_CYC     = 3000000
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EN,
   input  logic [3:0]  ECHO,
   output logic [3:0]  TRIG,
   output logic [15:0] DIST,
   output logic [1:0]  DIST_ID,
   output logic        DIST_VLD,
   output logic        TMO,
   output logic        BUSY
);

   localparam int CNT_MAX = (GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(TIMEOUT_CYC + 1);
   localparam int PW      = $clog2(CYC_PER_CM + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   state_t         state;
   logic [1:0]     sel;
   logic [CW-1:0]  cnt;
   logic [TW-1:0]  tmo_cnt;
   logic [PW-1:0]  presc;
   logic [15:0]    cm;
   logic [3:0]     echo_s1, echo_s2, echo_d;

   logic        echo_rise, echo_fall, tmo_hit, presc_wrap;
   logic [15:0] cm_next;

   assign echo_rise  = echo_s2[sel] & ~echo_d[sel];
   assign echo_fall  = ~echo_s2[sel] & echo_d[sel];
   assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign presc_wrap = (presc == PW'(CYC_PER_CM - 1));
   // The cycle in which the fall is seen still counts toward the distance.
   assign cm_next    = (presc_wrap && cm != 16'hFFFE) ? cm + 16'd1 : cm;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         sel      <= 2'd0;
         cnt      <= '0;
         tmo_cnt  <= '0;
         presc    <= '0;
         cm       <= 16'd0;
         echo_s1  <= 4'd0;
         echo_s2  <= 4'd0;
         echo_d   <= 4'd0;
         TRIG     <= 4'd0;
         DIST     <= 16'd0;
         DIST_ID  <= 2'd0;
         DIST_VLD <= 1'b0;
         TMO      <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         echo_s1  <= ECHO;
         echo_s2  <= echo_s1;
         echo_d   <= echo_s2;
         DIST_VLD <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (EN) begin
                  state <= ST_TRIG;
                  TRIG  <= 4'b0001 << sel;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            ST_TRIG: begin
               if (cnt == CW'(TRIG_CYC - 1)) begin
                  TRIG    <= 4'd0;
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_RISE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT_RISE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_hit) begin
                  DIST     <= 16'hFFFF;
                  DIST_ID  <= sel;
                  TMO      <= 1'b1;
                  DIST_VLD <= 1'b1;
                  cnt      <= '0;
                  state    <= ST_GAP;
               end else if (echo_rise) begin
                  presc <= '0;
                  cm    <= 16'd0;
                  state <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               presc   <= presc_wrap ? '0 : presc + 1'b1;
               cm      <= cm_next;
               // A falling edge beats a coincident timeout.
               if (echo_fall) begin
                  DIST     <= cm_next;
                  DIST_ID  <= sel;
                  TMO      <= 1'b0;
                  DIST_VLD <= 1'b1;
                  cnt      <= '0;
                  state    <= ST_GAP;
               end else if (tmo_hit) begin
                  DIST     <= 16'hFFFF;
                  DIST_ID  <= sel;
                  TMO      <= 1'b1;
                  DIST_VLD <= 1'b1;
                  cnt      <= '0;
                  state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == CW'(GAP_CYC - 1)) begin
                  sel <= sel + 2'd1;
                  cnt <= '0;
                  if (EN) begin
                     TRIG  <= 4'b0001 << (sel + 2'd1);
                     state <= ST_TRIG;
                  end else begin
                     BUSY  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               TRIG  <= 4'd0;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
